// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_sched_pkg
//  Description : Shared definitions for the adder scheduler: limb width,
//                FSM state encoding and a 4-bit ripple-carry helper used by
//                the carry-select slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // 4-bit ripple adder, returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] ripple4(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       c);
        logic [4:0] r;
        logic       cy;
        r  = '0;
        cy = c;
        for (int i = 0; i < 4; i++) begin
            r[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        r[4] = cy;
        return r;
    endfunction

endpackage : adder_sched_pkg
`default_nettype wire

// File: rtl/adder_sched_csel_add16.sv
`default_nettype none
// ============================================================================
//  Module      : csel_add16
//  Description : Combinational 16-bit carry-select adder slice. The low
//                nibble is a plain ripple block; each upper nibble is summed
//                for both carry-in values in parallel and the real carry
//                picks the result.
//  Ports       : a, b  - 16-bit operands
//                cin   - carry into bit 0
//                sum   - 16-bit result
//                cout  - carry out of bit 15
//  Revision    : 1.0 - initial release
// ============================================================================
module csel_add16
    import adder_sched_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // Upper-block speculative results, element j-1 belongs to nibble j.
    logic [2:0][4:0] w_r0;
    logic [2:0][4:0] w_r1;
    logic [4:0]      w_lo;
    logic [4:0]      w_sel;
    logic            w_cy;

    assign w_lo = ripple4(a[3:0], b[3:0], cin);

    generate
        for (genvar j = 1; j < 4; j++) begin : g_blk
            assign w_r0[j-1] = ripple4(a[4*j +: 4], b[4*j +: 4], 1'b0);
            assign w_r1[j-1] = ripple4(a[4*j +: 4], b[4*j +: 4], 1'b1);
        end
    endgenerate

    // Select chain: only a mux delay per nibble after the low block.
    always_comb begin
        sum      = '0;
        w_sel    = '0;
        sum[3:0] = w_lo[3:0];
        w_cy     = w_lo[4];
        for (int j = 1; j < 4; j++) begin
            w_sel          = w_cy ? w_r1[j-1] : w_r0[j-1];
            sum[4*j +: 4]  = w_sel[3:0];
            w_cy           = w_sel[4];
        end
        cout = w_cy;
    end

endmodule : csel_add16
`default_nettype wire

// File: rtl/adder_sched.sv
`default_nettype none
// ============================================================================
//  Module      : adder_sched
//  Description : Round-robin scheduler sharing one 16-bit carry-select slice
//                among NREQ requesters. Each accepted request is a LIMBS-limb
//                add processed least significant limb first with the carry
//                held in a register; the result is returned over a
//                valid/ready channel tagged with the requester index.
//  Ports       : clk, rst (async, active high)
//                req_valid/req_ready/req_a/req_b/req_cin - request side
//                req_sub   - subtract select (only with ADDSCHED_SUB_EN)
//                rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout - response side
//                busy      - high while a request is in RUN or DONE
//  Options     : ADDSCHED_SUB_EN - adds req_sub and B inversion for subtract
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LIMBS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*LIMB_W*LIMBS-1:0]    req_a,
    input  logic [NREQ*LIMB_W*LIMBS-1:0]    req_b,
    input  logic [NREQ-1:0]                 req_cin,
`ifdef ADDSCHED_SUB_EN
    input  logic [NREQ-1:0]                 req_sub,
`endif
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NREQ)-1:0]         rsp_id,
    output logic [LIMB_W*LIMBS-1:0]         rsp_sum,
    output logic                            rsp_cout,
    output logic                            busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int OPW = LIMB_W * LIMBS;
    localparam int KW  = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [KW-1:0]  C_LAST_K = KW'(LIMBS - 1);
    localparam logic [IDW-1:0] C_LAST_ID = IDW'(NREQ - 1);

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [KW-1:0]   r_k;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_sum;
    logic            r_carry;
    logic            r_cout;
`ifdef ADDSCHED_SUB_EN
    logic            r_sub;
`endif

    // ------------------------------------------------------------------
    // Round-robin search: rotate the valids so the pointer lands on bit 0,
    // take the first set bit, then map the offset back to a requester id.
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0] w_dbl;
    logic              w_found;
    logic [IDW:0]      w_sum_id;
    logic [IDW-1:0]    w_gnt_id;
    logic [IDW-1:0]    w_next_ptr;
    logic              w_accept;

    always_comb begin
        w_dbl    = {req_valid, req_valid} >> r_ptr;
        w_found  = 1'b0;
        w_sum_id = {1'b0, r_ptr};
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found  = 1'b1;
                w_sum_id = {1'b0, r_ptr} + (IDW+1)'(i);
            end
        end
        if (w_sum_id >= (IDW+1)'(NREQ)) begin
            w_sum_id = w_sum_id - (IDW+1)'(NREQ);
        end
        w_gnt_id = w_sum_id[IDW-1:0];
    end

    // Ready is suppressed while rst is high so nothing is offered during reset.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_IDLE && w_found && !rst) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_accept   = |(req_valid & req_ready);
    assign w_next_ptr = (w_gnt_id == C_LAST_ID) ? '0 : w_gnt_id + 1'b1;

    // ------------------------------------------------------------------
    // Limb mux and shared slice
    // ------------------------------------------------------------------
    logic [LIMB_W-1:0] w_a_limb;
    logic [LIMB_W-1:0] w_b_limb;
    logic [LIMB_W-1:0] w_slice_sum;
    logic              w_slice_cout;

    assign w_a_limb = r_a[r_k*LIMB_W +: LIMB_W];
`ifdef ADDSCHED_SUB_EN
    // a - b = a + ~b + 1; the +1 comes from the carry preload at acceptance.
    assign w_b_limb = r_sub ? ~r_b[r_k*LIMB_W +: LIMB_W] : r_b[r_k*LIMB_W +: LIMB_W];
`else
    assign w_b_limb = r_b[r_k*LIMB_W +: LIMB_W];
`endif

    csel_add16 u_slice (
        .a    (w_a_limb),
        .b    (w_b_limb),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef ADDSCHED_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a[w_gnt_id*OPW +: OPW];
                        r_b     <= req_b[w_gnt_id*OPW +: OPW];
`ifdef ADDSCHED_SUB_EN
                        r_sub   <= req_sub[w_gnt_id];
                        r_carry <= req_sub[w_gnt_id] | req_cin[w_gnt_id];
`else
                        r_carry <= req_cin[w_gnt_id];
`endif
                        r_id    <= w_gnt_id;
                        r_ptr   <= w_next_ptr;
                        r_k     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_k*LIMB_W +: LIMB_W] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    if (r_k == C_LAST_K) begin
                        r_cout  <= w_slice_cout;
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign busy      = (r_state != ST_IDLE);

endmodule : adder_sched
`default_nettype wire
